div_unit: RTL and testbench

- Multi-cycle integer divider for the EX stage of the RISC-V pipeline. It implements the M-extension divide group: DIV, DIVU, REM and REMU.
- It is the counterpart of the ALU's combinational multiplier. The hazard unit stalls the pipeline while busy=1.
- It uses a radix-2 restoring shift-subtract algorithm, one quotient bit per cycle, with RISC-V-defined divide-by-zero and overflow results.

---
 rtl/div_unit.sv | 174 +++++++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for the EX stage.
// Implements DIV / DIVU / REM / REMU with the RISC-V results for divide by
// zero and signed overflow. One quotient bit is produced per cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     divide request, honoured only in IDLE or DONE with flush low
//   flush     pipeline kill, returns to IDLE without a done pulse
//   func3     100=DIV, 101=DIVU, 110=REM, 111=REMU
//   alu_src1  dividend
//   alu_src2  divisor
//   busy      operation in progress (CALC or FIX), pipeline must stall
//   done      one-cycle pulse, div_out valid in this cycle
//   div_out   quotient or remainder, held until the next accepted start
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] div_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, dvs_r;
  logic            sign_q_r, sign_r_r, is_rem_r;
  logic [XLEN-1:0] div_out_r;
  logic            busy_r, done_r;

  logic            accept_s, signed_op_s, div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN:0]   shifted_s, diff_s;
  logic            ge_s;
  logic [XLEN-1:0] quo_fix_s, rem_fix_s;
  logic            unused_s;

  // Two's-complement magnitude; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    abs_val = v[XLEN-1] ? (ZERO - v) : v;
  endfunction

  // func3[2] is always 1 for the divide group and is not decoded.
  assign unused_s = func3[2];

  assign accept_s    = ((state_r == IDLE) || (state_r == DONE)) && start && !flush;
  assign signed_op_s = !func3[0];
  assign div_zero_s  = (alu_src2 == ZERO);
  assign ovf_s       = signed_op_s && (alu_src1 == MIN_NEG) && (alu_src2 == ONES);
  assign special_s   = div_zero_s || ovf_s;

  // Result loaded straight into div_out for the two special cases.
  always_comb begin
    special_res_s = ZERO;
    if (div_zero_s) begin
      special_res_s = func3[1] ? alu_src1 : ONES;
    end else begin
      special_res_s = func3[1] ? ZERO : MIN_NEG;
    end
  end

  // One restoring step. The running remainder is always below the divisor,
  // so the shifted value is below twice the divisor and the borrow out of
  // the (XLEN+1)-bit subtraction is exactly "shifted < divisor".
  assign shifted_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, dvs_r};
  assign ge_s      = !diff_s[XLEN];

  // Sign flags are only ever set for signed ops, so no extra gating here.
  assign quo_fix_s = sign_q_r ? (ZERO - quo_r) : quo_r;
  assign rem_fix_s = sign_r_r ? (ZERO - rem_r) : rem_r;

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_s = special_s ? DONE : CALC;
          else          state_s = IDLE;
        end
        CALC: begin
          if (cnt_r == {CW{1'b0}}) state_s = FIX;
          else                     state_s = CALC;
        end
        FIX:  state_s = DONE;
        DONE: begin
          if (accept_s) state_s = special_s ? DONE : CALC;
          else          state_s = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register plus busy/done flops decoded from the next state, so the
  // outputs are registered yet track the state with no extra latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CALC) || (state_s == FIX);
      done_r  <= (state_s == DONE);
    end
  end

  // Datapath: operand latch at accept, shift-subtract in CALC, sign fix-up
  // and result select in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      rem_r     <= ZERO;
      quo_r     <= ZERO;
      dvs_r     <= ZERO;
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      is_rem_r  <= 1'b0;
      div_out_r <= ZERO;
    end else if (accept_s) begin
      cnt_r    <= CW'(XLEN - 1);
      rem_r    <= ZERO;
      quo_r    <= signed_op_s ? abs_val(alu_src1) : alu_src1;
      dvs_r    <= signed_op_s ? abs_val(alu_src2) : alu_src2;
      sign_q_r <= signed_op_s && (alu_src1[XLEN-1] ^ alu_src2[XLEN-1]);
      sign_r_r <= signed_op_s && alu_src1[XLEN-1];
      is_rem_r <= func3[1];
      if (special_s) div_out_r <= special_res_s;
    end else if (!flush) begin
      case (state_r)
        CALC: begin
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          rem_r <= ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
          quo_r <= {quo_r[XLEN-2:0], ge_s};
        end
        FIX: begin
          div_out_r <= is_rem_r ? rem_fix_s : quo_fix_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign div_out = div_out_r;

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand-written flush / reset /
// back-to-back sequences. Outputs are sampled on the falling clock edge.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] alu_src1, alu_src2;
  logic        busy, done;
  logic [31:0] div_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .func3(func3),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .busy(busy), .done(done), .div_out(div_out)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: RISC-V divide semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
      end
    end else begin
      q = a / b; r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present a request for exactly one rising edge.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    func3 = f3; alu_src1 = a; alu_src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; check result, latency and busy cycle count.
  // With noise set, start pulses with a divide-by-zero request mid-CALC.
  task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat,
                           input int exp_busy, input bit noise);
    int n = 0;
    int nb = 0;
    bit got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (noise) begin
        if (n >= 5 && n <= 7) begin
          start = 1'b1; func3 = 3'b100; alu_src1 = $urandom; alu_src2 = 32'd0;
        end else begin
          start = 1'b0;
        end
      end
      if (busy) nb++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({name, "_result"}, div_out, exp);
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    int          l, dcount;

    vecs[0]  = '{3'b100, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{3'b110, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{3'b101, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  34};
    vecs[5]  = '{3'b111, 32'hFFFF_FFFF,  32'd2,          32'd1,          34};
    vecs[6]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{3'b110, 32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[11] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    vecs[12] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};

    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'b100;
    alu_src1 = 32'd0; alu_src2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_div_out", div_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat,
                (vecs[i].lat == 1) ? 0 : 33, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_drop", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_hold", i), div_out, vecs[i].exp);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      e = ref_div(f3, a, b);
      l = ref_lat(f3, a, b);
      launch(f3, a, b);
      wait_done($sformatf("rnd%0d_f%0b_%h_%h", i, f3, a, b), e, l, (l == 1) ? 0 : 33, 1'b0);
      @(negedge clk);
    end

    // Back-to-back: second start in the DONE cycle, start noise during CALC.
    launch(3'b100, 32'd100, 32'd7);
    wait_done("b2b_first", 32'd14, 34, 33, 1'b0);
    launch(3'b101, 32'd1000, 32'd10);
    wait_done("b2b_second", 32'd100, 34, 33, 1'b1);
    @(negedge clk);

    // Flush at iteration 10: no done, div_out keeps the previous result.
    launch(3'b100, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_div_out", div_out, 32'd100);
    dcount = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("flush_no_done_later", dcount, 0);

    // flush beats start in the same cycle (special-case request would show at once).
    func3 = 3'b100; alu_src1 = 32'd9; alu_src2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_prio_done", {31'd0, done}, 32'd0);
    chk("flush_prio_div_out", div_out, 32'd100);

    // Reset mid-CALC.
    launch(3'b100, 32'd1000, 32'd3);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_div_out", div_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(3'b100, 32'd1000, 32'd3);
    wait_done("after_reset", 32'd333, 34, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
